ps2_keyboard: RTL

PS2_KEYBOARD -- requirements
Module: ps2_keyboard

---
 rtl/ps2_keyboard_pkg.sv | 18 +
 rtl/ps2_keyboard_kb_fifo.sv | 47 ++++
 rtl/ps2_keyboard.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/ps2_keyboard_pkg.sv
// Shared constants, FSM encoding and parity helper for the PS/2 keyboard receiver.
package ps2_keyboard_pkg;

    localparam int PS2_FRAME_LEN = 11;
    localparam int DATA_W        = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    // Data plus parity must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [DATA_W:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/ps2_keyboard_kb_fifo.sv
// Small synchronous FIFO with extra-MSB pointers; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module kb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_wr_en;
    logic             w_rd_en;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_rd_en = i_pop && !o_empty;
    // When full, the write lands in the slot the simultaneous pop is vacating.
    assign w_wr_en = i_push && (!o_full || w_rd_en);
    assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: synchronises the PS/2 lines, deframes 11-bit frames
// with parity/stop/timeout checking and queues good scan codes in a FIFO.
module ps2_keyboard
    import ps2_keyboard_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic              kbi_clk,
    input  logic              kbi_rst,
    input  logic              kbi_ps2_clk,
    input  logic              kbi_ps2_data,
    input  logic              kbi_rdn,
    output logic              kbo_data_ready,
    output logic [DATA_W-1:0] kbo_scan_code,
    output logic              kbo_frame_error,
    output logic              kbo_overflow
);

    localparam int          TO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [3:0]  LAST_BIT = 4'(PS2_FRAME_LEN - 3);

    logic [1:0]        r_clk_sync;
    logic [1:0]        r_data_sync;
    logic              r_clk_prev;
    state_t            r_state;
    state_t            w_state_next;
    logic [3:0]        r_bit_cnt;
    logic [DATA_W:0]   r_shift;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_push;
    logic [DATA_W-1:0] r_push_data;
    logic              r_frame_error;
    logic              r_overflow;

    logic              w_fall;
    logic              w_bit;
    logic              w_timeout;
    logic              w_accept;
    logic              w_bad;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [DATA_W-1:0] w_fifo_data;

    // Synchronisers idle high so reset never looks like a PS/2 fall.
    always_ff @(posedge kbi_clk or posedge kbi_rst) begin
        if (kbi_rst) begin
            r_clk_sync  <= '1;
            r_data_sync <= '1;
            r_clk_prev  <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], kbi_ps2_clk};
            r_data_sync <= {r_data_sync[0], kbi_ps2_data};
            r_clk_prev  <= r_clk_sync[1];
        end
    end

    assign w_fall    = r_clk_prev && !r_clk_sync[1];
    assign w_bit     = r_data_sync[1];
    assign w_timeout = (r_state != ST_IDLE) && !w_fall &&
                       (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge kbi_clk or posedge kbi_rst) begin
        if (kbi_rst) r_state <= ST_IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_fall && !w_bit) w_state_next = ST_RECV;
            ST_RECV: begin
                if (w_timeout)                             w_state_next = ST_IDLE;
                else if (w_fall && r_bit_cnt == LAST_BIT)  w_state_next = ST_STOP;
            end
            ST_STOP: if (w_timeout || w_fall) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_accept = 1'b0;
        w_bad    = w_timeout;
        if (r_state == ST_STOP && w_fall) begin
            w_accept = w_bit && odd_parity_ok(r_shift);
            w_bad    = !w_accept;
        end
    end

    // Bits arrive LSB first, so shift in from the top; parity ends in the MSB.
    always_ff @(posedge kbi_clk or posedge kbi_rst) begin
        if (kbi_rst) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_to_cnt  <= '0;
        end else begin
            if (r_state == ST_IDLE) begin
                r_bit_cnt <= '0;
                if (w_fall && !w_bit) r_shift <= '0;
            end else if (r_state == ST_RECV && w_fall) begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
                r_shift   <= {w_bit, r_shift[DATA_W:1]};
            end
            if (r_state == ST_IDLE || w_fall || w_timeout) r_to_cnt <= '0;
            else                                           r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end

    assign w_pop = !kbi_rdn && !w_empty;

    always_ff @(posedge kbi_clk or posedge kbi_rst) begin
        if (kbi_rst) begin
            r_push        <= 1'b0;
            r_push_data   <= '0;
            r_frame_error <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_push        <= w_accept;
            r_push_data   <= r_shift[DATA_W-1:0];
            r_frame_error <= w_bad;
            r_overflow    <= r_push && w_full && !w_pop;
        end
    end

    kb_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (kbi_clk),
        .rst     (kbi_rst),
        .i_push  (r_push),
        .i_pop   (w_pop),
        .i_data  (r_push_data),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign kbo_data_ready  = !w_empty;
    assign kbo_scan_code   = w_fifo_data;
    assign kbo_frame_error = r_frame_error;
    assign kbo_overflow    = r_overflow;

endmodule
